idex_reg: RTL and testbench
===========================

// Module: idex_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
//  Captures decoded operands and control from ID and presents them to EX.
//  Supplies ex_rs/ex_rt to the forwarding unit in EX.
//  Inserts one bubble on a load-use hazard, clears on branch flush, and holds on an external stall.
// PARAMETERS
//  DW   32  datapath width (operands, pc, imm)
//  RW   5   register-index width
//  AW   4   ALU control width
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  ext_stall    in   1   global hold (multi-cycle mem/div); freezes the register
//  flush        in   1   branch/jump taken in EX; kill the instruction entering EX
//  id_pc        in   DW  PC+4 of the ID instruction
//  id_rs        in   RW  source register A index
//  id_rt        in   RW  source register B index
//  id_rd        in   RW  R-type destination index
//  id_busA      in   DW  register-file read A
//  id_busB      in   DW  register-file read B
//  id_imm32     in   DW  extended immediate
//  id_ctrl      in   9   {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,Branch,Jump,Shift}
//  id_aluctr    in   AW  ALU operation
//  pc_hold      out  1   hold PC this cycle (combinational)
//  ifid_hold    out  1   hold IF/ID this cycle (combinational)
//  ex_pc, ex_busA, ex_busB, ex_imm32   out  DW  registered copies
//  ex_rs, ex_rt, ex_rd                 out  RW  registered indices (ex_rs/ex_rt go to forwarding)
//  ex_rw        out  RW  registered destination: RegDst ? rd : rt
//  ex_ctrl      out  9   registered control bundle
//  ex_aluctr    out  AW  registered ALU op
// BEHAVIOUR
//  - Reset: on a clk edge with rst=1, all ex_* outputs become 0 (a NOP bubble).
//    pc_hold and ifid_hold are 0 while rst=1.
//  - Load-use hazard: lu = ex_ctrl.MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
//    Combinational from current register contents.
//  - Update priority at each edge: rst > ext_stall > flush > lu > normal.
//    - ext_stall: all ex_* keep their values; flush and lu are ignored.
//      The flush source keeps flush asserted until ext_stall drops.
//    - flush: ex_ctrl<=0, ex_aluctr<=0, ex_rs/rt/rd/rw<=0. Data fields are don't-care, driven 0.
//    - lu: same bubble as flush. pc_hold=ifid_hold=1 for exactly this cycle.
//    - normal: every ex_* field <= its id_* counterpart. ex_rw <= id_ctrl.RegDst ? id_rd : id_rt.
//  - pc_hold = ifid_hold = ~rst & (ext_stall | (lu & ~flush)). Flush wins over lu: the ID instruction is being killed anyway.
//  - Latency: 1 cycle ID->EX. A load-use costs exactly 1 bubble.
//    After the bubble ex_ctrl.MemRead=0, so lu deasserts and the consumer advances on the next edge.
//  - A bubble has RegWrite=0 and rw=0, so the forwarding unit never matches it.
//  - lu never fires when the load target is $0.
//  - Reset mid-stall: rst clears the register. lu then reads 0, and holds release the cycle after.
// STRUCTURE
//  - Shared header mips_defs.vh: DW/RW/AW, ctrl-bit index `defines (CTRL_REGWRITE.. CTRL_SHIFT), CTRL_W=9, NOP_CTRL=0.
//  - Sub-module hazard_detect: (ex_memread, ex_rt, id_rs, id_rt) -> lu, purely combinational.
//  - idex_reg: instantiates hazard_detect, contains one always @(posedge clk) priority block, plus the hold assigns.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> all ex_*=0; pc_hold=0.
//  2. ID: add rd=3, rs=1, rt=2; ctrl RegWrite=1, RegDst=1; no stall -> next cycle ex_rs=1, ex_rt=2, ex_rw=3, RegWrite=1.
//  3. lw rt=5 in EX; ID add rs=5 -> pc_hold=ifid_hold=1 for 1 cycle.
//     Next ex_ctrl=0, then the add enters EX with ex_rs=5.
//  4. lw rt=0 in EX; ID rs=0 -> lu=0, no bubble.
//  5. lu and flush in the same cycle -> bubble, pc_hold=0.
//     flush alone -> ex_ctrl=0, ex_rw=0.
//  6. ext_stall=1 for 3 cycles with flush=1 and changing id_* -> ex_* unchanged, pc_hold=1.
//     Release with flush still 1 -> bubble.
//     Also: rst asserted during a lu hold -> ex_*=0 and holds drop.

Source files
------------

// File: rtl/idex_reg_pkg.sv
// idex_reg_pkg: widths, control-bundle layout and payload types shared by the ID/EX register slice
package idex_reg_pkg;

   localparam int DW     = 32;
   localparam int RW     = 5;
   localparam int AW     = 4;
   localparam int CTRL_W = 9;

   // Bit positions inside the control bundle, MSB first
   localparam int CTRL_REGWRITE = 8;
   localparam int CTRL_MEMREAD  = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMTOREG = 5;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_REGDST   = 3;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_JUMP     = 1;
   localparam int CTRL_SHIFT    = 0;

   // Field order matches the CTRL_* indices above
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic reg_dst;
      logic branch;
      logic jump;
      logic shift;
   } ctrl_t;

   localparam ctrl_t NOP_CTRL = '0;

   // Everything the EX stage receives from ID, held as one register
   typedef struct packed {
      logic [DW-1:0] pc;
      logic [DW-1:0] bus_a;
      logic [DW-1:0] bus_b;
      logic [DW-1:0] imm32;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
      logic [RW-1:0] rw;
      ctrl_t         ctrl;
      logic [AW-1:0] aluctr;
   } idex_t;

   // What the register does on the next edge when not in reset
   typedef enum logic [1:0] {
      UPD_LOAD,
      UPD_HOLD,
      UPD_BUBBLE
   } upd_e;

   // Destination register: R-type writes rd, everything else writes rt
   function automatic logic [RW-1:0] dest_sel(ctrl_t c, logic [RW-1:0] rd, logic [RW-1:0] rt);
      return c.reg_dst ? rd : rt;
   endfunction

endpackage

// File: rtl/idex_reg_if.sv
// idex_reg_if: ID-side inputs, EX-side outputs and hazard holds of the ID/EX register
interface idex_reg_if;
   import idex_reg_pkg::*;

   logic          ext_stall;
   logic          flush;
   logic [DW-1:0] id_pc;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic [RW-1:0] id_rd;
   logic [DW-1:0] id_busA;
   logic [DW-1:0] id_busB;
   logic [DW-1:0] id_imm32;
   ctrl_t         id_ctrl;
   logic [AW-1:0] id_aluctr;
   logic          pc_hold;
   logic          ifid_hold;
   logic [DW-1:0] ex_pc;
   logic [DW-1:0] ex_busA;
   logic [DW-1:0] ex_busB;
   logic [DW-1:0] ex_imm32;
   logic [RW-1:0] ex_rs;
   logic [RW-1:0] ex_rt;
   logic [RW-1:0] ex_rd;
   logic [RW-1:0] ex_rw;
   ctrl_t         ex_ctrl;
   logic [AW-1:0] ex_aluctr;

   // ID stage / pipeline control side
   modport master (
      output ext_stall, flush, id_pc, id_rs, id_rt, id_rd, id_busA, id_busB, id_imm32, id_ctrl, id_aluctr,
      input  pc_hold, ifid_hold, ex_pc, ex_busA, ex_busB, ex_imm32, ex_rs, ex_rt, ex_rd, ex_rw, ex_ctrl, ex_aluctr
   );

   // The ID/EX register itself
   modport slave (
      input  ext_stall, flush, id_pc, id_rs, id_rt, id_rd, id_busA, id_busB, id_imm32, id_ctrl, id_aluctr,
      output pc_hold, ifid_hold, ex_pc, ex_busA, ex_busB, ex_imm32, ex_rs, ex_rt, ex_rd, ex_rw, ex_ctrl, ex_aluctr
   );

endinterface

// File: rtl/idex_reg_hazard_detect.sv
// idex_reg_hazard_detect: load-use detection between the load in EX and the instruction in ID
module idex_reg_hazard_detect
   import idex_reg_pkg::*;
(
   input  logic          ex_memread,
   input  logic [RW-1:0] ex_rt,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   output logic          lu
);

   // A load into $0 never produces a value worth waiting for
   assign lu = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/idex_reg.sv
// idex_reg: ID/EX pipeline register with load-use bubble, branch flush and external hold
module idex_reg
   import idex_reg_pkg::*;
(
   input logic        clk,
   input logic        rst,
   idex_reg_if.slave  bus
);

   idex_t cur;
   idex_t nxt;
   idex_t id_word;
   upd_e  upd;
   logic  lu;

   idex_reg_hazard_detect u_hazard (
      .ex_memread (cur.ctrl.mem_read),
      .ex_rt      (cur.rt),
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .lu         (lu)
   );

   assign id_word = '{
      pc:     bus.id_pc,
      bus_a:  bus.id_busA,
      bus_b:  bus.id_busB,
      imm32:  bus.id_imm32,
      rs:     bus.id_rs,
      rt:     bus.id_rt,
      rd:     bus.id_rd,
      rw:     dest_sel(bus.id_ctrl, bus.id_rd, bus.id_rt),
      ctrl:   bus.id_ctrl,
      aluctr: bus.id_aluctr
   };

   // Stall outranks flush, flush and load-use both insert an all-zero bubble
   always_comb begin
      upd = bus.ext_stall ? UPD_HOLD : (bus.flush | lu) ? UPD_BUBBLE : UPD_LOAD;
      nxt = (upd == UPD_LOAD) ? id_word : (upd == UPD_HOLD) ? cur : '0;
   end

   // Pipeline register; reset loads a NOP bubble
   always_ff @(posedge clk) begin
      if (rst) cur <= '0;
      else     cur <= nxt;
   end

   // A flushed ID instruction is discarded, so load-use must not hold the front end
   assign bus.pc_hold   = ~rst & (bus.ext_stall | (lu & ~bus.flush));
   assign bus.ifid_hold = ~rst & (bus.ext_stall | (lu & ~bus.flush));

   assign bus.ex_pc     = cur.pc;
   assign bus.ex_busA   = cur.bus_a;
   assign bus.ex_busB   = cur.bus_b;
   assign bus.ex_imm32  = cur.imm32;
   assign bus.ex_rs     = cur.rs;
   assign bus.ex_rt     = cur.rt;
   assign bus.ex_rd     = cur.rd;
   assign bus.ex_rw     = cur.rw;
   assign bus.ex_ctrl   = cur.ctrl;
   assign bus.ex_aluctr = cur.aluctr;

endmodule

// File: tb/tb_idex_reg.sv
// tb_idex_reg: scoreboard bench for the ID/EX register and its load-use holds
module tb_idex_reg;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  rw;
      logic [8:0]  ctrl;
      logic [3:0]  alu;
   } exp_t;

   localparam logic [8:0] LW  = 9'h1B0;
   localparam logic [8:0] ADD = 9'h108;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   exp_t m;
   exp_t q[$];

   idex_reg_if bus ();

   idex_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [8:0] c, input logic [31:0] pc);
      bus.id_pc     = pc;
      bus.id_rs     = rs;
      bus.id_rt     = rt;
      bus.id_rd     = rd;
      bus.id_busA   = 32'h1000_0000 | pc;
      bus.id_busB   = ~pc;
      bus.id_imm32  = pc << 4;
      bus.id_ctrl   = c;
      bus.id_aluctr = c[3:0] ^ pc[3:0];
   endtask

   task automatic step(input string tag);
      logic lu;
      logic h;
      exp_t nx;
      #1;
      lu = m.ctrl[7] && m.rt != 5'd0 && (m.rt == bus.id_rs || m.rt == bus.id_rt);
      h  = !rst && (bus.ext_stall || (lu && !bus.flush));
      check({tag, ".pc_hold"}, 32'(bus.pc_hold), 32'(h));
      check({tag, ".ifid_hold"}, 32'(bus.ifid_hold), 32'(h));
      nx = '{default: '0};
      if (!rst && bus.ext_stall) nx = m;
      else if (!rst && !bus.flush && !lu) begin
         nx.pc   = bus.id_pc;
         nx.a    = bus.id_busA;
         nx.b    = bus.id_busB;
         nx.imm  = bus.id_imm32;
         nx.rs   = bus.id_rs;
         nx.rt   = bus.id_rt;
         nx.rd   = bus.id_rd;
         nx.rw   = bus.id_ctrl[3] ? bus.id_rd : bus.id_rt;
         nx.ctrl = bus.id_ctrl;
         nx.alu  = bus.id_aluctr;
      end
      q.push_back(nx);
      m = nx;
      @(posedge clk);
      #1;
      nx = q.pop_front();
      check({tag, ".ex_pc"}, bus.ex_pc, nx.pc);
      check({tag, ".ex_busA"}, bus.ex_busA, nx.a);
      check({tag, ".ex_busB"}, bus.ex_busB, nx.b);
      check({tag, ".ex_imm32"}, bus.ex_imm32, nx.imm);
      check({tag, ".ex_rs"}, 32'(bus.ex_rs), 32'(nx.rs));
      check({tag, ".ex_rt"}, 32'(bus.ex_rt), 32'(nx.rt));
      check({tag, ".ex_rd"}, 32'(bus.ex_rd), 32'(nx.rd));
      check({tag, ".ex_rw"}, 32'(bus.ex_rw), 32'(nx.rw));
      check({tag, ".ex_ctrl"}, 32'(bus.ex_ctrl), 32'(nx.ctrl));
      check({tag, ".ex_aluctr"}, 32'(bus.ex_aluctr), 32'(nx.alu));
   endtask

   initial begin
      clk = 0;
      rst = 1;
      n_chk = 0;
      n_fail = 0;
      m = '{default: '0};
      bus.ext_stall = 0;
      bus.flush = 0;
      id(5'd9, 5'd9, 5'd9, LW, 32'h44);
      step("reset0");
      step("reset1");
      rst = 0;
      id(5'd1, 5'd2, 5'd3, ADD, 32'h100);
      step("add");
      check("add.ex_rw_is_rd", 32'(bus.ex_rw), 32'd3);
      id(5'd1, 5'd5, 5'd0, LW, 32'h104);
      step("lw5");
      id(5'd5, 5'd6, 5'd7, ADD, 32'h108);
      step("lu_bubble");
      check("lu_bubble.ctrl_zero", 32'(bus.ex_ctrl), 32'd0);
      step("lu_advance");
      check("lu_advance.ex_rs", 32'(bus.ex_rs), 32'd5);
      id(5'd1, 5'd0, 5'd0, LW, 32'h10C);
      step("lw0");
      id(5'd0, 5'd0, 5'd4, ADD, 32'h110);
      step("lw0_no_lu");
      id(5'd2, 5'd5, 5'd0, LW, 32'h114);
      step("lw5b");
      id(5'd5, 5'd3, 5'd8, ADD, 32'h118);
      bus.flush = 1;
      step("lu_flush");
      id(5'd4, 5'd6, 5'd9, ADD, 32'h11C);
      step("flush_only");
      bus.flush = 0;
      id(5'd4, 5'd6, 5'd9, ADD, 32'h120);
      step("pre_stall");
      bus.ext_stall = 1;
      bus.flush = 1;
      for (int i = 0; i < 3; i++) begin
         id(5'(i + 10), 5'(i + 11), 5'(i + 12), LW, 32'h200 + 32'(i * 4));
         step("stall");
      end
      bus.ext_stall = 0;
      step("stall_release_flush");
      bus.flush = 0;
      id(5'd1, 5'd7, 5'd0, LW, 32'h300);
      step("lw7");
      id(5'd7, 5'd2, 5'd3, ADD, 32'h304);
      #1;
      check("lu_pre_rst.pc_hold", 32'(bus.pc_hold), 32'd1);
      rst = 1;
      step("rst_in_lu");
      rst = 0;
      step("after_rst");
      for (int i = 0; i < 80; i++) begin
         id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            9'($urandom), $urandom);
         bus.ext_stall = ($urandom_range(0, 5) == 0);
         bus.flush = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 30) == 0);
         step("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
